reg_file_wb: RTL and testbench

//  32-entry integer register file for the single-cycle RISC-V core; write-back sink of the

---
 rtl/reg_file_wb.sv | 79 +++++++
 tb/tb_reg_file_wb.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_wb.sv
// ---------------------------------------------------------------------------
// reg_file_wb
//  32-entry integer register file for the single-cycle RISC-V core. It is the
//  write-back sink of the register-select mux, it provides two combinational
//  read ports (rs1/rs2) and it has one synchronous write port. x0 always reads
//  zero and has no storage. x2 (sp) resets to SP_INIT. Every other register
//  resets to zero.
//
//  Ports
//   clk        in   1        core clock; writes on rising edge
//   reset      in   1        asynchronous, active-high; reinitialises array
//   reg_write  in   1        write enable from control unit
//   rd_addr    in   ADDR_W   destination register index
//   wr_data    in   DATA_W   write-back data
//   rs1_addr   in   ADDR_W   read port 1 index
//   rs2_addr   in   ADDR_W   read port 2 index
//   rs1_data   out  DATA_W   read port 1 data (combinational)
//   rs2_data   out  DATA_W   read port 2 data (combinational)
//
//  Configuration macro
//   REGFILE_BYPASS_EN  when defined, a write in flight is forwarded to any read
//                      port that addresses the same non-zero register in the
//                      same cycle. When undefined, a colliding read returns
//                      the old array contents.
// ---------------------------------------------------------------------------
module reg_file_wb #(
   parameter int                DATA_W  = 32,
   parameter int                ADDR_W  = 5,
   parameter logic [DATA_W-1:0] SP_INIT = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [DATA_W-1:0] rs1_data,
   output logic [DATA_W-1:0] rs2_data
);

   localparam int DEPTH = 2**ADDR_W;

   // Index 0 is deliberately absent: x0 has no flop.
   logic [DATA_W-1:0] regs [1:DEPTH-1];

   logic wr_en;
   assign wr_en = reg_write && (rd_addr != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < DEPTH; i++) begin
            regs[ADDR_W'(i)] <= (i == 2) ? SP_INIT : '0;
         end
      end else if (wr_en) begin
         regs[rd_addr] <= wr_data;
      end
   end

   logic [DATA_W-1:0] rs1_arr;
   logic [DATA_W-1:0] rs2_arr;

   always_comb begin
      rs1_arr = '0;
      rs2_arr = '0;
      if (rs1_addr != '0) rs1_arr = regs[rs1_addr];
      if (rs2_addr != '0) rs2_arr = regs[rs2_addr];
   end

`ifdef REGFILE_BYPASS_EN
   // Forward the write in flight. wr_en already excludes rd=0, so x0 stays 0.
   assign rs1_data = (wr_en && (rs1_addr == rd_addr)) ? wr_data : rs1_arr;
   assign rs2_data = (wr_en && (rs2_addr == rd_addr)) ? wr_data : rs2_arr;
`else
   assign rs1_data = rs1_arr;
   assign rs2_data = rs2_arr;
`endif

endmodule

// File: tb/tb_reg_file_wb.sv
module tb_reg_file_wb;

   localparam logic [31:0] SP_VAL = 32'h0000_8000;

   logic        clk;
   logic        clk_en;
   logic        reset;
   logic        reg_write;
   logic [4:0]  rd_addr;
   logic [31:0] wr_data;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;

   int vectors;
   int miscompares;

   reg_file_wb #(
      .DATA_W  (32),
      .ADDR_W  (5),
      .SP_INIT (SP_VAL)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .reg_write (reg_write),
      .rd_addr   (rd_addr),
      .wr_data   (wr_data),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data)
   );

   initial clk = 1'b0;
   always #5 clk = clk_en ? ~clk : 1'b0;

   always @(posedge clk) begin
      if (!reset) begin
         assert (!$isunknown(reg_write))
            else $error("reg_write is unknown while out of reset");
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
         else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
         end
   endtask

   task automatic do_write(input logic [4:0] rd, input logic [31:0] data);
      @(negedge clk);
      reg_write = 1'b1;
      rd_addr   = rd;
      wr_data   = data;
      @(negedge clk);
      reg_write = 1'b0;
   endtask

   initial begin
      logic [31:0] exp;
      vectors     = 0;
      miscompares = 0;
      clk_en      = 1'b0;
      reset       = 1'b0;
      reg_write   = 1'b0;
      rd_addr     = '0;
      wr_data     = '0;
      rs1_addr    = '0;
      rs2_addr    = '0;

      // 1: reset pulse with the clock stopped
      #1 reset = 1'b1;
      rs1_addr = 5'd2;
      rs2_addr = 5'd5;
      #2;
      check("rst_sp_rs1", rs1_data, SP_VAL);
      check("rst_x5_rs2", rs2_data, 32'h0);
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i);
         rs2_addr = 5'(31 - i);
         #1;
         check($sformatf("rst_sweep_rs1_x%0d", i), rs1_data, (i == 2) ? SP_VAL : 32'h0);
         check($sformatf("rst_sweep_rs2_x%0d", 31 - i), rs2_data, ((31 - i) == 2) ? SP_VAL : 32'h0);
      end
      #2 reset = 1'b0;
      #2 clk_en = 1'b1;

      // 2: basic write, then a disabled write must not change it
      rs1_addr = 5'd5;
      do_write(5'd5, 32'hDEAD_BEEF);
      #1 check("wr_x5", rs1_data, 32'hDEAD_BEEF);
      @(negedge clk);
      reg_write = 1'b0;
      rd_addr   = 5'd5;
      wr_data   = 32'h0;
      @(negedge clk);
      #1 check("nowr_x5", rs1_data, 32'hDEAD_BEEF);

      // 3: writes to x0 are dropped; also no forwarding onto x0
      rs1_addr = 5'd0;
      rs2_addr = 5'd0;
      @(negedge clk);
      reg_write = 1'b1;
      rd_addr   = 5'd0;
      wr_data   = 32'hFFFF_FFFF;
      #1 check("x0_during_wr", rs1_data, 32'h0);
      @(negedge clk);
      reg_write = 1'b0;
      #1;
      check("x0_rs1", rs1_data, 32'h0);
      check("x0_rs2", rs2_data, 32'h0);

      // 4: same-cycle read/write collision on x7
      rs1_addr = 5'd7;
      rs2_addr = 5'd6;
      @(negedge clk);
      reg_write = 1'b1;
      rd_addr   = 5'd7;
      wr_data   = 32'h1234_5678;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("coll_pre", rs1_data, 32'h1234_5678);
`else
      check("coll_pre", rs1_data, 32'h0);
`endif
      check("coll_other_port", rs2_data, 32'h0);
      @(negedge clk);
      reg_write = 1'b0;
      #1 check("coll_post", rs1_data, 32'h1234_5678);

      // 5: pattern fill of x1..x31 and a sweep on both ports
      for (int i = 1; i < 32; i++) begin
         do_write(5'(i), 32'(i) * 32'h0101_0101);
      end
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i);
         rs2_addr = 5'(31 - i);
         #1;
         exp = 32'(i) * 32'h0101_0101;
         check($sformatf("pat_rs1_x%0d", i), rs1_data, exp);
         exp = 32'(31 - i) * 32'h0101_0101;
         check($sformatf("pat_rs2_x%0d", 31 - i), rs2_data, exp);
      end
      rs1_addr = 5'd13;
      rs2_addr = 5'd13;
      #1;
      check("same_addr_rs1", rs1_data, 32'h0D0D_0D0D);
      check("same_addr_rs2", rs2_data, 32'h0D0D_0D0D);

      // 6: reset raised 1 ns before the edge of a pending write to x9
      @(negedge clk);
      reg_write = 1'b1;
      rd_addr   = 5'd9;
      wr_data   = 32'hA5A5_A5A5;
      #4 reset = 1'b1;
      #3;
      reset     = 1'b0;
      reg_write = 1'b0;
      rs1_addr  = 5'd9;
      rs2_addr  = 5'd2;
      #1;
      check("rstwr_x9", rs1_data, 32'h0);
      check("rstwr_sp", rs2_data, SP_VAL);
      rs1_addr = 5'd31;
      #1 check("rstwr_x31", rs1_data, 32'h0);

      // Post-reset write still works
      rs1_addr = 5'd9;
      do_write(5'd9, 32'h0BAD_F00D);
      #1 check("postrst_wr_x9", rs1_data, 32'h0BAD_F00D);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
